// File: rtl/twiddle_pkg.sv
// Shared helpers for the twiddle-factor generator: quarter-wave ROM contents and the
// quadrant fold that rebuilds a full-circle coefficient from two ROM words.
package twiddle_pkg;

  localparam real Pi = 3.14159265358979323846;

  typedef struct packed {
    logic signed [63:0] re;
    logic signed [63:0] im;
  } cpx_t;

  // Quarter-wave ROM depth: N/4+1 words for an N = 2^log2n point transform.
  function automatic int qlen(input int log2n);
    return (1 << (log2n - 2)) + 1;
  endfunction

  // cos(2*pi*i/N) in fixed point, truncated toward zero; endpoints forced exact.
  function automatic longint cos_q(input int i, input int log2n, input int frac);
    real x;
    real x2;
    real term;
    real sum;
    if (i == 0) return longint'(1) << frac;
    if (i == (1 << (log2n - 2))) return 0;
    x    = 2.0 * Pi * real'(i) / real'(longint'(1) << log2n);
    x2   = x * x;
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n <= 16; n++) begin
      term = -term * x2 / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    return longint'($rtoi(sum * real'(longint'(1) << frac)));
  endfunction

  // a = C(x), b = C(N/4-x); quad set when k >= N/4 (x = k-N/4 there).
  function automatic cpx_t fold(input logic quad, input logic inv, input longint a,
                                input longint b);
    cpx_t r;
    if (!quad) begin
      r.re = a;
      r.im = -b;
    end else begin
      r.re = -b;
      r.im = -a;
    end
    if (inv) r.im = -r.im;
    return r;
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine ROM with two synchronous read ports, contents built at elaboration.
module twiddle_qrom
  import twiddle_pkg::*;
#(
  parameter int LOG2N = 4,
  parameter int W_W   = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic [LOG2N-2:0] addr_a_i,
  input  logic [LOG2N-2:0] addr_b_i,
  output logic [W_W-1:0]   data_a_o,
  output logic [W_W-1:0]   data_b_o
);

  localparam int QLEN = qlen(LOG2N);

  logic [W_W-1:0] rom [QLEN];
  logic [W_W-1:0] data_a_d, data_a_q;
  logic [W_W-1:0] data_b_d, data_b_q;

  for (genvar i = 0; i < QLEN; i++) begin : g_rom
    assign rom[i] = W_W'(cos_q(i, LOG2N, FRAC));
  end

  always_comb begin
    data_a_d = rom[addr_a_i];
    data_b_d = rom[addr_b_i];
  end

  always_ff @(posedge clk) begin
    data_a_q <= data_a_d;
    data_b_q <= data_b_d;
  end

  assign data_a_o = data_a_q;
  assign data_b_o = data_b_q;

endmodule

// File: rtl/twiddle_gen.sv
// Twiddle-factor generator for a radix-2 SDF DIF FFT: one coefficient per butterfly
// stage per accepted sample, two-cycle fixed latency.
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int LOG2N  = 4,
  parameter int W_W    = 32,
  parameter int FRAC   = 16,
  parameter int STAGES = LOG2N - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  sync,
  input  logic                  inverse,
  output logic [STAGES*W_W-1:0] tw_re,
  output logic [STAGES*W_W-1:0] tw_im,
  output logic                  tw_valid,
  output logic                  frame_start
);

  localparam int             KW  = LOG2N - 1;
  localparam logic [KW-1:0]  Qtr = KW'(1 << (LOG2N - 2));
  localparam logic [W_W-1:0] One = W_W'(longint'(1) << FRAC);

  logic [LOG2N-1:0]      cnt_q, cnt_d, c;
  logic                  inv_q, inv_d;
  logic                  valid_q;
  logic                  first_d, first_q;
  logic                  invp_q;
  logic [KW-1:0]         k      [STAGES];
  logic [KW-1:0]         addr_a [STAGES];
  logic [KW-1:0]         addr_b [STAGES];
  logic [STAGES-1:0]     quad_d, quad_q;
  logic [W_W-1:0]        rom_a  [STAGES];
  logic [W_W-1:0]        rom_b  [STAGES];
  cpx_t                  fold_r [STAGES];
  logic [STAGES*W_W-1:0] tw_re_d, tw_re_q, tw_im_d, tw_im_q;
  logic                  tw_valid_q;
  logic                  frame_start_d, frame_start_q;

  // Sample counter and per-frame inverse latch; sample 0 already sees the new mode.
  always_comb begin
    c       = sync ? '0 : cnt_q;
    first_d = (c == '0);
    cnt_d   = cnt_q;
    if (in_valid) cnt_d = c + 1'b1;
    else if (sync) cnt_d = '0;
    inv_d = (in_valid && first_d) ? inverse : inv_q;
  end

  // k = 0 when the stage's half bit is clear, else the low bits scaled by 2^s.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      k[s] = '0;
      if (c[LOG2N-1-s]) k[s] = KW'((c & LOG2N'((1 << (LOG2N - 1 - s)) - 1)) << s);
      quad_d[s] = k[s][KW-1];
      addr_a[s] = {1'b0, k[s][KW-2:0]};
      addr_b[s] = Qtr - addr_a[s];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    twiddle_qrom #(
      .LOG2N(LOG2N),
      .W_W  (W_W),
      .FRAC (FRAC)
    ) u_qrom (
      .clk     (clk),
      .addr_a_i(addr_a[s]),
      .addr_b_i(addr_b[s]),
      .data_a_o(rom_a[s]),
      .data_b_o(rom_b[s])
    );
  end

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      fold_r[s] = fold(quad_q[s], invp_q, longint'($signed(rom_a[s])),
                       longint'($signed(rom_b[s])));
    end
  end

  // Outputs only move on a valid sample so bubbles hold the last coefficients.
  always_comb begin
    tw_re_d       = tw_re_q;
    tw_im_d       = tw_im_q;
    frame_start_d = valid_q & first_q;
    if (valid_q) begin
      for (int s = 0; s < STAGES; s++) begin
        tw_re_d[s*W_W +: W_W] = W_W'(fold_r[s].re);
        tw_im_d[s*W_W +: W_W] = W_W'(fold_r[s].im);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      inv_q         <= 1'b0;
      valid_q       <= 1'b0;
      first_q       <= 1'b0;
      invp_q        <= 1'b0;
      quad_q        <= '0;
      tw_re_q       <= {STAGES{One}};
      tw_im_q       <= '0;
      tw_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      inv_q         <= inv_d;
      valid_q       <= in_valid;
      first_q       <= first_d;
      invp_q        <= inv_d;
      quad_q        <= quad_d;
      tw_re_q       <= tw_re_d;
      tw_im_q       <= tw_im_d;
      tw_valid_q    <= valid_q;
      frame_start_q <= frame_start_d;
    end
  end

  assign tw_re       = tw_re_q;
  assign tw_im       = tw_im_q;
  assign tw_valid    = tw_valid_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_twiddle_gen.sv
// Directed bench for twiddle_gen (LOG2N=4) plus a random stream on a LOG2N=6 instance
// compared against trig-based expectations.
module tb_twiddle_gen;

  localparam int  W  = 32;
  localparam real Pi = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           iv4 = 1'b0, sy4 = 1'b0, inv4 = 1'b0;
  logic [3*W-1:0] re4, im4;
  logic           v4, fs4;
  logic           iv6 = 1'b0, sy6 = 1'b0, inv6 = 1'b0;
  logic [5*W-1:0] re6, im6;
  logic           v6, fs6;

  twiddle_gen #(.LOG2N(4), .W_W(W), .FRAC(16)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .sync(sy4), .inverse(inv4),
    .tw_re(re4), .tw_im(im4), .tw_valid(v4), .frame_start(fs4)
  );

  twiddle_gen #(.LOG2N(6), .W_W(W), .FRAC(16)) u6 (
    .clk(clk), .rst(rst), .in_valid(iv6), .sync(sy6), .inverse(inv6),
    .tw_re(re6), .tw_im(im6), .tw_valid(v6), .frame_start(fs6)
  );

  int n_chk = 0;
  int n_err = 0;
  int t     = 0;

  logic [3*W-1:0] sre [512];
  logic [3*W-1:0] sim [512];
  logic           sv  [512];
  logic           sfs [512];

  logic   ev6 [400];
  logic   ef6 [400];
  longint er6 [400][5];
  longint ei6 [400][5];

  int     f0, f1, f2, fb;
  int     c6, nval, h, k;
  logic   invm, vv, ii;
  real    th;

  function automatic longint sx(input logic [W-1:0] x);
    return longint'($signed(x));
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_lane(input string tag, input int i, input int s, input longint er,
                          input longint ei);
    chk({tag, "_re"}, sx(sre[i][s*W +: W]), er);
    chk({tag, "_im"}, sx(sim[i][s*W +: W]), ei);
  endtask

  // Snapshot outputs at the negedge, then drive this cycle's inputs.
  task automatic cyc(input logic v, input logic s, input logic inv);
    sre[t] = re4;
    sim[t] = im4;
    sv[t]  = v4;
    sfs[t] = fs4;
    iv4    = v;
    sy4    = s;
    inv4   = inv;
    @(negedge clk);
    t++;
  endtask

  initial begin
    for (int i = 0; i < 400; i++) begin
      ev6[i] = 1'b0;
      ef6[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Get part way into a frame, then reset.
    for (int j = 0; j < 5; j++) cyc(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    iv4 = 1'b0;
    #1;
    chk("rst_valid", longint'(v4), 0);
    chk("rst_fs", longint'(fs4), 0);
    for (int s = 0; s < 3; s++) begin
      chk("rst_re", sx(re4[s*W +: W]), 65536);
      chk("rst_im", sx(im4[s*W +: W]), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    f0 = t;
    for (int j = 0; j < 16; j++) cyc(1'b1, 1'b0, 1'b0);
    f1 = t;
    for (int j = 0; j < 16; j++) cyc(1'b1, 1'b0, (j < 5));
    f2 = t;
    for (int j = 0; j < 16; j++) cyc(1'b1, 1'b0, 1'b0);

    fb = t;
    for (int j = 0; j < 9; j++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 11; j++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    chk("pre_valid0", longint'(sv[f0]), 0);
    chk("pre_valid1", longint'(sv[f0 + 1]), 0);
    chk("first_valid", longint'(sv[f0 + 2]), 1);
    chk("first_fs", longint'(sfs[f0 + 2]), 1);
    chk("second_fs", longint'(sfs[f0 + 3]), 0);
    chk_lane("s0_c9", f0 + 11, 0, 60547, -25079);
    chk_lane("s0_c12", f0 + 14, 0, 0, -65536);
    chk_lane("s0_c3", f0 + 5, 0, 65536, 0);
    chk_lane("s1_c7", f0 + 9, 1, -46340, -46340);
    chk_lane("s2_c3", f0 + 5, 2, 0, -65536);

    chk_lane("inv_s0_c9", f1 + 11, 0, 60547, 25079);
    chk_lane("inv_s0_c12", f1 + 14, 0, 0, 65536);
    chk_lane("inv_s0_c3", f1 + 5, 0, 65536, 0);
    chk_lane("inv_s2_c3", f1 + 5, 2, 0, 65536);
    chk_lane("fwd_s0_c9", f2 + 11, 0, 60547, -25079);

    chk("bub_v0", longint'(sv[fb + 11]), 1);
    chk("bub_v1", longint'(sv[fb + 12]), 0);
    chk("bub_v2", longint'(sv[fb + 13]), 1);
    chk("bub_v3", longint'(sv[fb + 14]), 0);
    chk_lane("bub_c9", fb + 11, 0, 60547, -25079);
    chk_lane("bub_hold9", fb + 12, 0, 60547, -25079);
    chk_lane("bub_c10", fb + 13, 0, 46340, -46340);
    chk_lane("bub_hold10", fb + 14, 0, 46340, -46340);
    chk("bub_fs", longint'(sfs[fb + 12]), 0);

    chk("sync_fs", longint'(sfs[fb + 26]), 1);
    chk("sync_valid", longint'(sv[fb + 26]), 1);
    for (int s = 0; s < 3; s++) chk_lane("sync_w1", fb + 26, s, 65536, 0);
    chk("after_sync_fs", longint'(sfs[fb + 27]), 0);
    chk_lane("after_sync_s1", fb + 27, 1, 65536, 0);
    chk("sync_idle_fs", longint'(sfs[fb + 29]), 1);

    // LOG2N=6 random stream over three frames.
    c6   = 0;
    nval = 0;
    invm = 1'b0;
    for (int i = 0; i < 320; i++) begin
      if (ev6[i]) begin
        for (int s = 0; s < 5; s++) begin
          chk("l6_re", sx(re6[s*W +: W]), er6[i][s]);
          chk("l6_im", sx(im6[s*W +: W]), ei6[i][s]);
        end
        chk("l6_fs", longint'(fs6), longint'(ef6[i]));
      end
      chk("l6_valid", longint'(v6), longint'(ev6[i]));
      vv = (nval < 192) && ($urandom_range(0, 3) != 0);
      ii = 1'($urandom_range(0, 1));
      if (vv) begin
        if (c6 == 0) invm = ii;
        for (int s = 0; s < 5; s++) begin
          h  = (c6 >> (5 - s)) & 1;
          k  = (h != 0) ? ((c6 & ((1 << (5 - s)) - 1)) << s) : 0;
          th = 2.0 * Pi * real'(k) / 64.0;
          er6[i+2][s] = longint'($rtoi($cos(th) * 65536.0));
          ei6[i+2][s] = longint'($rtoi(-$sin(th) * 65536.0));
          if (invm) ei6[i+2][s] = -ei6[i+2][s];
        end
        ev6[i+2] = 1'b1;
        ef6[i+2] = (c6 == 0);
        c6       = (c6 + 1) % 64;
        nval++;
      end
      iv6  = vv;
      inv6 = ii;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
